// File: rtl/systolic_feed_ctrl.sv
// Preload/run sequencer for the systolic MAC array: strobes DIM rows into their
// FIFOs, then issues row-skewed shift enables, waits out the drain and pulses done.

module systolic_feed_lane #(
    parameter int LANE  = 0,
    parameter int DEPTH = 8,
    parameter int CW    = 5,
    parameter int RW    = 4
) (
    input  logic          run,
    input  logic [CW-1:0] cyc,
    input  logic          wr_ok,
    input  logic [RW-1:0] row_cnt,
    output logic          en,
    output logic          wr
);
    localparam int            SPAN_I = 2 * DEPTH;
    localparam logic [CW:0]   BASE   = LANE[CW:0];
    localparam logic [CW:0]   SPAN   = SPAN_I[CW:0];
    localparam logic [RW-1:0] ROW    = LANE[RW-1:0];

    // One extra bit so the borrow flags cyc < LANE; this avoids a constant
    // compare for lane 0.
    logic [CW:0] ofs;

    assign ofs = {1'b0, cyc} - BASE;
    assign en  = run & ~ofs[CW] & (ofs < SPAN);
    assign wr  = wr_ok & (row_cnt == ROW);
endmodule

module systolic_feed_ctrl #(
    parameter int DIM   = 8,
    parameter int DEPTH = 8,
    parameter int DRAIN = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic           load_valid,
    output logic           load_ready,
    output logic [DIM-1:0] fifo_wr,
    output logic [DIM-1:0] fifo_en,
    output logic           acc_clr,
    output logic           busy,
    output logic           done
);
    localparam int CW       = $clog2(2 * DEPTH + DIM);
    localparam int RW       = $clog2(DIM + 1);
    localparam int DW       = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam int CYC_LAST_I = 2 * DEPTH + DIM - 2;
    localparam int ROW_LAST_I = DIM - 1;
    localparam int DRN_LAST_I = DRAIN - 1;
    localparam logic [CW-1:0] CYC_LAST = CYC_LAST_I[CW-1:0];
    localparam logic [RW-1:0] ROW_LAST = ROW_LAST_I[RW-1:0];
    localparam logic [DW-1:0] DRN_LAST = DRN_LAST_I[DW-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state, nxt;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] cyc;
    logic [DW-1:0] drn;
    logic          accept;
    logic          run;

    assign accept = (state == S_LOAD) & load_valid & ~abort;
    assign run    = (state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) nxt = S_LOAD;
                S_LOAD:  if (accept && row_cnt == ROW_LAST) nxt = S_RUN;
                S_RUN:   if (cyc == CYC_LAST) nxt = S_DRAIN;
                S_DRAIN: if (drn == DRN_LAST) nxt = S_DONE;
                S_DONE:  nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // Counters run only in their own state and are cleared whenever we sit in
    // IDLE or abort, so every new sequence starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
            cyc     <= '0;
            drn     <= '0;
        end else if (abort || state == S_IDLE) begin
            row_cnt <= '0;
            cyc     <= '0;
            drn     <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) row_cnt <= row_cnt + 1'b1;
                    cyc <= '0;
                end
                S_RUN: begin
                    cyc <= cyc + 1'b1;
                    drn <= '0;
                end
                S_DRAIN: drn <= drn + 1'b1;
                default: ;
            endcase
        end
    end

    genvar i;
    for (i = 0; i < DIM; i++) begin : g_lane
        systolic_feed_lane #(
            .LANE (i),
            .DEPTH(DEPTH),
            .CW   (CW),
            .RW   (RW)
        ) u_lane (
            .run    (run),
            .cyc    (cyc),
            .wr_ok  (accept),
            .row_cnt(row_cnt),
            .en     (fifo_en[i]),
            .wr     (fifo_wr[i])
        );
    end

    // acc_clr comes straight from start, so it is held off while in reset.
    assign acc_clr    = (state == S_IDLE) & start & ~abort & rst_n;
    assign load_ready = (state == S_LOAD) & ~abort;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: scoreboarded row strobes, modelled RUN windows,
// abort, start/abort collisions and asynchronous reset.

module tb_systolic_feed_ctrl;
    localparam int DIM     = 8;
    localparam int DEPTH   = 8;
    localparam int DRAIN   = 4;
    localparam int RUN_LEN = 2 * DEPTH + DIM - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           load_valid = 1'b0;
    logic           load_ready;
    logic [DIM-1:0] fifo_wr;
    logic [DIM-1:0] fifo_en;
    logic           acc_clr;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;
    logic [DIM-1:0] wr_q[$];

    always #5 clk = ~clk;

    systolic_feed_ctrl #(.DIM(DIM), .DEPTH(DEPTH), .DRAIN(DRAIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .fifo_wr   (fifo_wr),
        .fifo_en   (fifo_en),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .done      (done)
    );

    // Start a sequence and push DIM rows; gappy gives valid pattern 1,0,0,1,0,0,...
    // Returns positioned at the negedge of the first RUN cycle.
    task automatic do_load(input bit gappy);
        int n = 0;
        int rows = 0;
        logic [DIM-1:0] oh, exp;
        @(negedge clk);
        start = 1'b1; abort = 1'b0; load_valid = 1'b0;
        #1;
        checks++;
        if ({acc_clr, busy} !== 2'b10) begin
            errors++; $display("FAIL start_cycle: {acc_clr,busy}=%b expected 10", {acc_clr, busy});
        end
        @(negedge clk);
        start = 1'b0;
        while (rows < DIM && n < 64) begin
            load_valid = gappy ? (n % 3 == 0) : 1'b1;
            if (load_valid) begin
                oh = '0; oh[rows] = 1'b1;
                wr_q.push_back(oh);
                rows++;
            end
            #1;
            checks++;
            if ({busy, load_ready} !== 2'b11) begin
                errors++; $display("FAIL load_state: {busy,load_ready}=%b expected 11", {busy, load_ready});
            end
            exp = (wr_q.size() > 0) ? wr_q.pop_front() : '0;
            checks++;
            if (fifo_wr !== exp) begin
                errors++; $display("FAIL fifo_wr beat %0d: got %h expected %h", n, fifo_wr, exp);
            end
            n++;
            @(negedge clk);
        end
        load_valid = 1'b0;
        if (rows < DIM) begin
            checks++; errors++;
            $display("FAIL load_timeout: rows=%0d expected %0d", rows, DIM);
        end
    endtask

    // Check the full RUN window, DRAIN and the done pulse; start_at>=0 pulses start mid-RUN.
    task automatic do_run(input int start_at);
        int hi[DIM];
        logic [DIM-1:0] exp;
        for (int i = 0; i < DIM; i++) hi[i] = 0;
        for (int c = 0; c < RUN_LEN; c++) begin
            if (c > 0) @(negedge clk);
            start = (c == start_at);
            #1;
            for (int i = 0; i < DIM; i++) exp[i] = (c >= i) && (c < i + 2 * DEPTH);
            checks++;
            if (fifo_en !== exp) begin
                errors++; $display("FAIL fifo_en cyc %0d: got %h expected %h", c, fifo_en, exp);
            end
            checks++;
            if ({busy, load_ready, done, acc_clr, fifo_wr} !== {4'b1000, {DIM{1'b0}}}) begin
                errors++;
                $display("FAIL run_ctl cyc %0d: {busy,rdy,done,clr,wr}=%b expected 1000_0", c,
                         {busy, load_ready, done, acc_clr, fifo_wr});
            end
            for (int i = 0; i < DIM; i++) if (fifo_en[i] === 1'b1) hi[i]++;
        end
        start = 1'b0;
        for (int i = 0; i < DIM; i++) begin
            checks++;
            if (hi[i] != 2 * DEPTH) begin
                errors++; $display("FAIL en_len row %0d: got %0d expected %0d", i, hi[i], 2 * DEPTH);
            end
        end
        for (int d = 0; d < DRAIN; d++) begin
            @(negedge clk); #1;
            checks++;
            if ({busy, done, fifo_en} !== {2'b10, {DIM{1'b0}}}) begin
                errors++; $display("FAIL drain %0d: {busy,done,en}=%b expected 10_0", d, {busy, done, fifo_en});
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b11) begin
            errors++; $display("FAIL done_pulse: {busy,done}=%b expected 11", {busy, done});
        end
        @(negedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL post_done: {busy,done}=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({load_ready, fifo_wr, fifo_en, acc_clr, busy, done} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 0",
                               {load_ready, fifo_wr, fifo_en, acc_clr, busy, done});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({busy, load_ready, done} !== 3'b000) begin
            errors++; $display("FAIL reset_idle: {busy,rdy,done}=%b expected 000", {busy, load_ready, done});
        end
    endtask

    task automatic test_back_to_back;
        do_load(1'b0);
        do_run(-1);
    endtask

    task automatic test_stall;
        do_load(1'b1);
        do_run(-1);
    endtask

    task automatic test_abort;
        logic [DIM-1:0] exp;
        int ndone = 0;
        // Abort arriving together with a beat in LOAD
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0; load_valid = 1'b1; abort = (k == 2);
            #1;
            exp = '0;
            if (k < 2) exp[k] = 1'b1;
            checks++;
            if (fifo_wr !== exp) begin
                errors++; $display("FAIL abort_load wr %0d: got %h expected %h", k, fifo_wr, exp);
            end
        end
        @(negedge clk); abort = 1'b0; load_valid = 1'b0; #1;
        checks++;
        if ({busy, load_ready} !== 2'b00) begin
            errors++; $display("FAIL abort_load_idle: {busy,rdy}=%b expected 00", {busy, load_ready});
        end
        // Abort at cyc 5 of RUN
        do_load(1'b0);
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            abort = (c == 5);
            #1;
            if (c < 5) begin
                for (int i = 0; i < DIM; i++) exp[i] = (c >= i);
                checks++;
                if (fifo_en !== exp) begin
                    errors++; $display("FAIL abort_run en cyc %0d: got %h expected %h", c, fifo_en, exp);
                end
            end
        end
        @(negedge clk); abort = 1'b0; #1;
        checks++;
        if ({busy, fifo_en} !== {1'b0, {DIM{1'b0}}}) begin
            errors++; $display("FAIL abort_run_idle: {busy,en}=%b expected 0", {busy, fifo_en});
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", ndone);
        end
        do_load(1'b0);
        do_run(-1);
    endtask

    task automatic test_start_abort;
        int ndone = 0;
        @(negedge clk); start = 1'b1; abort = 1'b1; #1;
        checks++;
        if (acc_clr !== 1'b0) begin
            errors++; $display("FAIL start_abort_clr: got %b expected 0", acc_clr);
        end
        @(negedge clk); start = 1'b0; abort = 1'b0; #1;
        checks++;
        if ({busy, load_ready} !== 2'b00) begin
            errors++; $display("FAIL start_abort_idle: {busy,rdy}=%b expected 00", {busy, load_ready});
        end
        do_load(1'b0);
        do_run(10);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++; $display("FAIL start_in_run_ignored: got %0d busy/done cycles expected 0", ndone);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); start = 1'b0; load_valid = 1'b1;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({load_ready, fifo_wr, fifo_en, acc_clr, busy, done} !== '0) begin
            errors++; $display("FAIL async_reset: got %b expected 0",
                               {load_ready, fifo_wr, fifo_en, acc_clr, busy, done});
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({busy, load_ready, fifo_wr} !== {2'b00, {DIM{1'b0}}}) begin
                errors++; $display("FAIL reset_release %0d: {busy,rdy,wr}=%b expected 0", k,
                                   {busy, load_ready, fifo_wr});
            end
        end
        load_valid = 1'b0;
        do_load(1'b0);
        do_run(-1);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_abort();
        test_start_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
